// File: rtl/mux_scan_pkg.sv
// Shared constants and state encoding for the 4:1 mux scan sequencer.
package mux_scan_pkg;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned SEL_W  = 2;

    typedef enum logic {
        IDLE,
        SCAN
    } scan_state_t;

endpackage

// File: rtl/scan_out_reg.sv
// Valid/ready holding register for completed snapshots, with a sticky overrun flag.
module scan_out_reg #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             snap_load,
    input  logic [WIDTH-1:0] snap_data,
    input  logic             data_ready,
    input  logic             clr_ovr,
    output logic [WIDTH-1:0] data,
    output logic             data_valid,
    output logic             overrun
);

    logic drop;

    // A new snapshot is lost only when the held one is still pending and not being taken.
    assign drop = snap_load && data_valid && !data_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data       <= '0;
            data_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (snap_load && !drop) begin
                data       <= snap_data;
                data_valid <= 1'b1;
            end else if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end

            if (drop) begin
                overrun <= 1'b1;
            end else if (clr_ovr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Steps the 4:1 mux select, samples each channel after a settle delay and emits 4-bit snapshots.
module mux_scan_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter int unsigned NUM_CH        = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic                            cont,
    output logic [mux_scan_pkg::SEL_W-1:0]  sel,
    input  logic                            mux_y,
    output logic [3:0]                      data,
    output logic                            data_valid,
    input  logic                            data_ready,
    output logic                            busy,
    output logic                            overrun,
    input  logic                            clr_ovr
);

    import mux_scan_pkg::*;

    localparam int unsigned CNT_W = (SETTLE_CYCLES == 0) ? 1 : $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SETTLE_CYCLES);
    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_CH - 1);

    scan_state_t      state_q;
    logic [SEL_W-1:0] ch_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       part_q;
    logic             sample_now;
    logic             snap_load;
    logic [3:0]       snap_data;

    assign sample_now = (state_q == SCAN) && (cnt_q == CNT_MAX);
    assign snap_load  = sample_now && (ch_q == LAST_CH);
    // The last channel bypasses the partial buffer so the snapshot is ready on its sample edge.
    assign snap_data  = {mux_y, part_q};

    // ch_q is held at 0 while idle, so it can drive the select directly.
    assign sel  = ch_q;
    assign busy = (state_q != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ch_q    <= '0;
            cnt_q   <= '0;
            part_q  <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start || cont) begin
                        state_q <= SCAN;
                        ch_q    <= '0;
                        cnt_q   <= '0;
                    end
                end
                SCAN: begin
                    if (!sample_now) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end else begin
                        cnt_q <= '0;
                        if (ch_q != LAST_CH) begin
                            part_q[ch_q] <= mux_y;
                            ch_q         <= ch_q + SEL_W'(1);
                        end else begin
                            ch_q <= '0;
                            if (!cont) begin
                                state_q <= IDLE;
                            end
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    scan_out_reg #(
        .WIDTH (4)
    ) u_out_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .snap_load  (snap_load),
        .snap_data  (snap_data),
        .data_ready (data_ready),
        .clr_ovr    (clr_ovr),
        .data       (data),
        .data_valid (data_valid),
        .overrun    (overrun)
    );

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Scoreboard bench: two sequencers (settle 1 and settle 0) each driving a modelled 4:1 mux.
module tb_mux_scan_ctrl;

    logic clk = 1'b0;
    logic rst_n;

    logic       start_a, cont_a, ready_a, clr_a, y_a, valid_a, busy_a, ovr_a;
    logic [1:0] sel_a;
    logic [3:0] i_a, data_a;
    logic       start_b, cont_b, ready_b, clr_b, y_b, valid_b, busy_b, ovr_b;
    logic [1:0] sel_b;
    logic [3:0] i_b, data_b;

    logic [3:0] q_a[$];
    logic [3:0] q_b[$];
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign y_a = i_a[sel_a];
    assign y_b = i_b[sel_b];

    mux_scan_ctrl #(
        .SETTLE_CYCLES (1)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start_a),
        .cont       (cont_a),
        .sel        (sel_a),
        .mux_y      (y_a),
        .data       (data_a),
        .data_valid (valid_a),
        .data_ready (ready_a),
        .busy       (busy_a),
        .overrun    (ovr_a),
        .clr_ovr    (clr_a)
    );

    mux_scan_ctrl #(
        .SETTLE_CYCLES (0)
    ) u_dut0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start_b),
        .cont       (cont_b),
        .sel        (sel_b),
        .mux_y      (y_b),
        .data       (data_b),
        .data_valid (valid_b),
        .data_ready (ready_b),
        .busy       (busy_b),
        .overrun    (ovr_b),
        .clr_ovr    (clr_b)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Monitors: a handshake seen at the falling edge completes on the next rising edge.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && valid_a && ready_a) begin
            if (q_a.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL snap_a_unexpected: got %b, expected no snapshot", data_a);
            end else begin
                check("snap_a", {4'b0, data_a}, {4'b0, q_a.pop_front()});
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1 && valid_b && ready_b) begin
            if (q_b.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL snap_b_unexpected: got %b, expected no snapshot", data_b);
            end else begin
                check("snap_b", {4'b0, data_b}, {4'b0, q_b.pop_front()});
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        {start_a, cont_a, ready_a, clr_a} = '0;
        {start_b, cont_b, ready_b, clr_b} = '0;
        i_a = '0;
        i_b = '0;
        tick();
        tick();
        check("rst_sel", {6'b0, sel_a}, 8'd0);
        check("rst_data", {4'b0, data_a}, 8'd0);
        check("rst_valid", {7'b0, valid_a}, 8'd0);
        check("rst_busy", {7'b0, busy_a}, 8'd0);
        check("rst_ovr", {7'b0, ovr_a}, 8'd0);
        check("rst_busy_b", {7'b0, busy_b}, 8'd0);
        rst_n = 1'b1;
        tick();

        // Single shot, held until accepted
        i_a = 4'b1010;
        q_a.push_back(4'b1010);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check("ss_sel", {6'b0, sel_a}, 8'(k / 2));
            check("ss_busy", {7'b0, busy_a}, 8'd1);
            tick();
        end
        check("ss_valid", {7'b0, valid_a}, 8'd1);
        check("ss_data", {4'b0, data_a}, 8'b1010);
        check("ss_busy_end", {7'b0, busy_a}, 8'd0);
        check("ss_sel_end", {6'b0, sel_a}, 8'd0);
        repeat (3) tick();
        check("ss_hold_valid", {7'b0, valid_a}, 8'd1);
        check("ss_hold_data", {4'b0, data_a}, 8'b1010);
        ready_a = 1'b1;
        tick();
        ready_a = 1'b0;
        check("ss_accept", {7'b0, valid_a}, 8'd0);

        // Start while busy is ignored
        i_a = 4'b0101;
        q_a.push_back(4'b0101);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        tick();
        tick();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (4) tick();
        check("sb_busy_e7", {7'b0, busy_a}, 8'd1);
        tick();
        check("sb_busy_e8", {7'b0, busy_a}, 8'd0);
        check("sb_data", {4'b0, data_a}, 8'b0101);
        ready_a = 1'b1;
        tick();
        ready_a = 1'b0;
        for (int k = 0; k < 9; k++) begin
            check("sb_idle", {6'b0, busy_a, valid_a}, 8'd0);
            tick();
        end

        // Continuous with backpressure
        i_a = 4'b0110;
        q_a.push_back(4'b0110);
        cont_a = 1'b1;
        tick();
        repeat (8) tick();
        check("bp_valid", {7'b0, valid_a}, 8'd1);
        check("bp_data", {4'b0, data_a}, 8'b0110);
        check("bp_ovr0", {7'b0, ovr_a}, 8'd0);
        check("bp_busy", {7'b0, busy_a}, 8'd1);
        repeat (8) tick();
        check("bp_ovr1", {7'b0, ovr_a}, 8'd1);
        check("bp_data_kept", {4'b0, data_a}, 8'b0110);
        cont_a = 1'b0;
        repeat (7) tick();
        check("bp_busy_e23", {7'b0, busy_a}, 8'd1);
        tick();
        check("bp_busy_e24", {7'b0, busy_a}, 8'd0);
        check("bp_ovr_still", {7'b0, ovr_a}, 8'd1);
        clr_a = 1'b1;
        tick();
        clr_a = 1'b0;
        check("bp_ovr_clr", {7'b0, ovr_a}, 8'd0);
        check("bp_data_final", {4'b0, data_a}, 8'b0110);
        ready_a = 1'b1;
        tick();
        ready_a = 1'b0;
        check("bp_accept", {7'b0, valid_a}, 8'd0);

        // Accept and load on the same edge
        i_a = 4'b1100;
        q_a.push_back(4'b1100);
        cont_a = 1'b1;
        tick();
        repeat (8) tick();
        check("al_data1", {4'b0, data_a}, 8'b1100);
        i_a = 4'b0011;
        q_a.push_back(4'b0011);
        repeat (7) tick();
        ready_a = 1'b1;
        tick();
        ready_a = 1'b0;
        cont_a = 1'b0;
        check("al_valid", {7'b0, valid_a}, 8'd1);
        check("al_data2", {4'b0, data_a}, 8'b0011);
        check("al_ovr", {7'b0, ovr_a}, 8'd0);
        q_a.push_back(4'b0011);
        repeat (7) tick();
        ready_a = 1'b1;
        tick();
        ready_a = 1'b0;
        check("al_valid3", {7'b0, valid_a}, 8'd1);
        check("al_ovr3", {7'b0, ovr_a}, 8'd0);
        check("al_busy3", {7'b0, busy_a}, 8'd0);
        ready_a = 1'b1;
        tick();
        ready_a = 1'b0;
        check("al_drained", {7'b0, valid_a}, 8'd0);

        // Reset mid-scan discards everything
        i_a = 4'b1111;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        check("mr_sel", {6'b0, sel_a}, 8'd0);
        check("mr_busy", {7'b0, busy_a}, 8'd0);
        check("mr_valid", {7'b0, valid_a}, 8'd0);
        rst_n = 1'b1;
        ready_a = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            check("mr_no_snap", {7'b0, valid_a}, 8'd0);
        end
        ready_a = 1'b0;

        // Settle 0, continuous, per-edge sampling of bit 2
        i_b = 4'b1001;
        ready_b = 1'b1;
        q_b.push_back(4'b1001);
        q_b.push_back(4'b1001);
        q_b.push_back(4'b1101);
        cont_b = 1'b1;
        tick();
        for (int k = 0; k < 12; k++) begin
            check("z_sel", {6'b0, sel_b}, 8'(k % 4));
            if (k == 4 || k == 8) check("z_valid", {7'b0, valid_b}, 8'd1);
            if (k == 5 || k == 10) i_b[2] = 1'b1;
            if (k == 6 || k == 11) i_b[2] = 1'b0;
            if (k == 9) cont_b = 1'b0;
            tick();
        end
        check("z_valid_last", {7'b0, valid_b}, 8'd1);
        check("z_busy_end", {7'b0, busy_b}, 8'd0);
        check("z_sel_end", {6'b0, sel_b}, 8'd0);
        repeat (3) tick();
        ready_b = 1'b0;

        check("q_a_empty", 8'(q_a.size()), 8'd0);
        check("q_b_empty", 8'(q_b.size()), 8'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mux_scan_ctrl.md
Name: mux_scan_ctrl

Overview:
- Sequencer that sits directly upstream of the 4:1 mux. It drives the mux select, waits a programmable settle time per channel, samples the mux output, and assembles the 4 samples into one snapshot word.
- The snapshot is presented through a valid/ready output register.
- Supports a single-shot scan (start pulse) and free-running continuous scanning.

Parameters:
- SETTLE_CYCLES, 1, extra cycles held on each channel before sampling; legal range 0..255.
- NUM_CH, 4, channel count; fixed by the 4:1 mux; not to be overridden.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  synchronous reset, active-low.
- start  input  1  begin one scan; sampled only in IDLE.
- cont  input  1  continuous mode; re-evaluated at the end of each scan.
- sel  output  2  mux select; drives the mux s input.
- mux_y  input  1  mux output y.
- data  output  4  snapshot; bit k = mux_y sampled while sel==k.
- data_valid  output  1  snapshot available.
- data_ready  input  1  consumer accepts the snapshot.
- busy  output  1  scan in progress (state != IDLE).
- overrun  output  1  sticky flag: a completed snapshot was dropped.
- clr_ovr  input  1  clears overrun.

Behaviour:
- Reset: sampled with rst_n low at a rising edge.
  - Outputs: sel=0, data=0, data_valid=0, busy=0, overrun=0.
  - Internal: state=IDLE, ch=0, cnt=0, partial buffer=0.
  - Reset mid-scan discards partial samples; no snapshot is produced.
- States: IDLE, SCAN.
- IDLE:
  - sel=0.
  - Edge with start=1 or cont=1 → SCAN, with ch=0 and cnt=0.
- SCAN:
  - sel=ch.
  - Each edge: if cnt<SETTLE_CYCLES, cnt++.
  - Else (cnt==SETTLE_CYCLES):
    - buf[ch] <= mux_y, cnt <= 0.
    - If ch<3: ch++.
    - If ch==3 (scan complete): deliver snapshot {mux_y, buf[2:0]}; then:
      - cont=1: ch=0 and stay in SCAN, with no idle gap.
      - Otherwise: → IDLE.
- Latency:
  - start sampled at edge E0 → snapshot delivered at edge E0 + 4*(SETTLE_CYCLES+1).
  - Each channel is held for SETTLE_CYCLES+1 cycles.
- start while busy is ignored; it is not queued.
- cont dropped mid-scan: the current scan finishes, then → IDLE.
- Output register:
  - data and data_valid hold stable until data_valid & data_ready at an edge; data_valid then clears.
  - Snapshot delivery edge:
    - data_valid=0, or data_valid=1 with data_ready=1 (accept and new data on the same edge): load data and set data_valid=1.
    - data_valid=1 with data_ready=0: drop the new snapshot, keep the old one, set overrun=1.
  - Output register operation is independent of FSM state.
- overrun: cleared by clr_ovr=1 at an edge. If a set and a clear occur on the same edge, set wins.
- Counter width: max(1, clog2(SETTLE_CYCLES+1)).
- SETTLE_CYCLES=0: one sample per cycle; sel advances every cycle.
- Channel wrap: after ch 3 the next channel is 0.

Decomposition:
- Package mux_scan_pkg holds:
  - NUM_CH=4 and SEL_W=2.
  - The state enum scan_state_t {IDLE, SCAN}.
- Sub-module scan_out_reg: the valid/ready holding register plus overrun logic.
  - Inputs: snap_load, snap_data, data_ready, clr_ovr.
  - Outputs: data, data_valid, overrun.
- The FSM, channel counter and settle counter stay in the top module.

Test Plan:
- Single-shot, SETTLE_CYCLES=1:
  - Stimulus: bench mux model with i=4'b1010, start pulse at E0, data_ready=0.
  - Required: sel sequence 0,0,1,1,2,2,3,3; at E8 data=4'b1010, data_valid=1, busy=0; data held until data_ready is given.
- Continuous backpressure:
  - Stimulus: SETTLE_CYCLES=1, cont=1, data_ready=0, i=4'b0110.
  - Required: valid at E8 with data 4'b0110; at E16 overrun=1 and data is unchanged; clr_ovr pulse → overrun=0.
- Simultaneous accept/load:
  - Stimulus: cont=1, data_ready=1 exactly on delivery edges, i changed to 4'b0011 between scans.
  - Required: data_valid stays 1, data updates to 4'b0011, overrun=0.
- Reset mid-scan:
  - Stimulus: rst_n=0 at E3 of a scan.
  - Required: next cycle sel=0, busy=0, data_valid=0; no snapshot ever appears from that scan.
- SETTLE_CYCLES=0, continuous:
  - Required: sel=0,1,2,3,0,… changing every cycle; snapshot every 4 cycles.
  - Stimulus: i[2] toggled while sel==1.
  - Required: bit 2 reflects i[2] at its own sample edge only.
- start while busy:
  - Stimulus: second start pulse at E3 of a single-shot scan.
  - Required: ignored; busy falls at E8; exactly one snapshot is produced.
